// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RISC sequencing controller: FSM states, opcode/ALU-op
// fields, decoder register selects, write-back selects and an instruction classifier.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WR_IMM,
    S_LD_A,
    S_LD_B,
    S_EXEC,
    S_WR_REG,
    S_HALT
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // MOV shares the ALU_op field to pick its immediate vs register form.
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] REG_SEL_RM = 2'b00;
  localparam logic [1:0] REG_SEL_RD = 2'b01;
  localparam logic [1:0] REG_SEL_RN = 2'b10;

  localparam logic [1:0] WB_SEL_C    = 2'b00;
  localparam logic [1:0] WB_SEL_IMM8 = 2'b10;

  typedef enum logic [2:0] {
    I_MOV_IMM,
    I_MOV_REG,
    I_MVN,
    I_ADD,
    I_CMP,
    I_AND,
    I_ILLEGAL
  } instr_t;

  function automatic instr_t classify(input logic [2:0] opc, input logic [1:0] op);
    instr_t ins;
    ins = I_ILLEGAL;
    if (opc == OPC_MOV) begin
      if (op == MOV_IMM)      ins = I_MOV_IMM;
      else if (op == MOV_REG) ins = I_MOV_REG;
    end else if (opc == OPC_ALU) begin
      case (op)
        ALU_ADD: ins = I_ADD;
        ALU_CMP: ins = I_CMP;
        ALU_AND: ins = I_AND;
        default: ins = I_MVN;
      endcase
    end
    return ins;
  endfunction

endpackage

// File: rtl/seq_controller.sv
// Multi-cycle Moore sequencer for the simple RISC datapath: one instruction per start.
// Optional macro SEQ_CTRL_ILLEGAL_TRAP_EN adds an `illegal` output and a sticky halt state.
module seq_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  output logic       waiting,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B
`ifdef SEQ_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_opcode;
  logic [1:0] r_alu_op;
  instr_t     w_dec_instr;
  instr_t     w_cur_instr;

  // Decode runs on the live IR fields; later states use the copy latched in S_DECODE.
  assign w_dec_instr = classify(opcode, ALU_op);
  assign w_cur_instr = classify(r_opcode, r_alu_op);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_WAIT;
      r_opcode <= '0;
      r_alu_op <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
        r_alu_op <= ALU_op;
      end
    end
  end

  // NOTE: every signal written here gets a default first so no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    w_next    = r_state;
    waiting   = 1'b0;
    reg_sel   = REG_SEL_RM;
    wb_sel    = WB_SEL_C;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
`ifdef SEQ_CTRL_ILLEGAL_TRAP_EN
    illegal   = 1'b0;
`endif
    case (r_state)
      S_WAIT: begin
        waiting = 1'b1;
        if (start) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_dec_instr)
          I_MOV_IMM:             w_next = S_WR_IMM;
          I_MOV_REG, I_MVN:      w_next = S_LD_B;
          I_ADD, I_CMP, I_AND:   w_next = S_LD_A;
          default: begin
`ifdef SEQ_CTRL_ILLEGAL_TRAP_EN
            w_next = S_HALT;
`else
            w_next = S_WAIT;
`endif
          end
        endcase
      end
      S_WR_IMM: begin
        reg_sel = REG_SEL_RN;
        wb_sel  = WB_SEL_IMM8;
        w_en    = 1'b1;
        w_next  = S_WAIT;
      end
      S_LD_A: begin
        reg_sel = REG_SEL_RN;
        en_A    = 1'b1;
        w_next  = S_LD_B;
      end
      S_LD_B: begin
        reg_sel = REG_SEL_RM;
        en_B    = 1'b1;
        w_next  = S_EXEC;
      end
      S_EXEC: begin
        // MOV-reg and MVN pass B straight through the ALU by zeroing A.
        sel_A = (w_cur_instr == I_MOV_REG) || (w_cur_instr == I_MVN);
        if (w_cur_instr == I_CMP) begin
          en_status = 1'b1;
          w_next    = S_WAIT;
        end else begin
          en_C   = 1'b1;
          w_next = S_WR_REG;
        end
      end
      S_WR_REG: begin
        reg_sel = REG_SEL_RD;
        wb_sel  = WB_SEL_C;
        w_en    = 1'b1;
        w_next  = S_WAIT;
      end
      S_HALT: begin
`ifdef SEQ_CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b1;
        w_next  = S_HALT;
`else
        w_next  = S_WAIT;
`endif
      end
      default: w_next = S_WAIT;
    endcase
  end

  // At most one datapath load/write strobe is active in any state.
  a_one_strobe: assert property (@(posedge clk) disable iff (rst)
    $onehot0({w_en, en_A, en_B, en_C, en_status}));

  a_wen_state: assert property (@(posedge clk) disable iff (rst)
    w_en |-> (r_state == S_WR_IMM || r_state == S_WR_REG));

endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench for seq_controller: stimulus pushes the expected per-cycle output
// vector sequence, a negedge monitor pops and compares each cycle's outputs.
module tb_seq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] ALU_op;
  logic       waiting;
  logic [1:0] reg_sel;
  logic [1:0] wb_sel;
  logic       w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic       illegal_o;

  seq_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opcode    (opcode),
    .ALU_op    (ALU_op),
    .waiting   (waiting),
    .reg_sel   (reg_sel),
    .wb_sel    (wb_sel),
    .w_en      (w_en),
    .en_A      (en_A),
    .en_B      (en_B),
    .en_C      (en_C),
    .en_status (en_status),
    .sel_A     (sel_A),
    .sel_B     (sel_B)
`ifdef SEQ_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal   (illegal_o)
`endif
  );

`ifndef SEQ_CTRL_ILLEGAL_TRAP_EN
  assign illegal_o = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic       illegal;
    logic       waiting;
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       en_A;
    logic       en_B;
    logic       en_C;
    logic       en_status;
    logic       sel_A;
    logic       sel_B;
  } vec_t;

  typedef enum {P_WAIT, P_DEC, P_WRI, P_LDA, P_LDB, P_EXA, P_EXC, P_CMP, P_WRR, P_HALT, P_NONE} phase_t;
  typedef phase_t ph6_t [6];

  typedef struct {
    vec_t  v;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Hand-written expected outputs per sequencer phase.
  function automatic vec_t vec_of(input phase_t p);
    vec_t v;
    v = '0;
    case (p)
      P_WAIT: v.waiting = 1'b1;
      P_WRI:  begin v.reg_sel = 2'b10; v.wb_sel = 2'b10; v.w_en = 1'b1; end
      P_LDA:  begin v.reg_sel = 2'b10; v.en_A = 1'b1; end
      P_LDB:  begin v.reg_sel = 2'b00; v.en_B = 1'b1; end
      P_EXA:  begin v.en_C = 1'b1; v.sel_A = 1'b1; end
      P_EXC:  v.en_C = 1'b1;
      P_CMP:  v.en_status = 1'b1;
      P_WRR:  begin v.reg_sel = 2'b01; v.wb_sel = 2'b00; v.w_en = 1'b1; end
      P_HALT: v.illegal = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input phase_t p, input string tag);
    exp_t e;
    e.v   = vec_of(p);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a full output vector every cycle.
  vec_t act;
  exp_t cur;
  always @(negedge clk) begin
    act = {illegal_o, waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B};
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check(cur.tag, 32'(act), 32'(cur.v));
    end
  end

  // Issue one instruction from S_WAIT; expected phases are listed by the caller.
  task automatic run(input logic [2:0] opc, input logic [1:0] op, input bit hold,
                     input string tag, input int len, input ph6_t ph);
    start  = 1'b1;
    opcode = opc;
    ALU_op = op;
    for (int i = 0; i < len; i++) push(ph[i], $sformatf("%s[%0d]", tag, i));
    for (int i = 0; i < len; i++) begin
      step();
      if (i == 0 && !hold) start = 1'b0;
      if (i == 1) begin
        opcode = ~opc;
        ALU_op = ~op;
      end
    end
  endtask

  task automatic idle(input int n, input string tag);
    start = 1'b0;
    for (int i = 0; i < n; i++) push(P_WAIT, $sformatf("%s[%0d]", tag, i));
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    opcode = 3'b000;
    ALU_op = 2'b00;
    step();
    // Reset holds S_WAIT even with start asserted.
    start = 1'b1;
    for (int i = 0; i < 3; i++) push(P_WAIT, $sformatf("reset[%0d]", i));
    repeat (3) step();
    rst = 1'b0;
    idle(2, "post_reset");

    run(3'b110, 2'b10, 1'b0, "mov_imm", 3, '{P_WAIT, P_DEC, P_WRI, P_NONE, P_NONE, P_NONE});
    idle(1, "gap0");
    run(3'b101, 2'b00, 1'b0, "add", 6, '{P_WAIT, P_DEC, P_LDA, P_LDB, P_EXC, P_WRR});
    run(3'b101, 2'b01, 1'b0, "cmp", 5, '{P_WAIT, P_DEC, P_LDA, P_LDB, P_CMP, P_NONE});
    run(3'b101, 2'b10, 1'b0, "and", 6, '{P_WAIT, P_DEC, P_LDA, P_LDB, P_EXC, P_WRR});
    idle(2, "gap1");

    // start held high: each instruction accepted in the single S_WAIT cycle.
    run(3'b101, 2'b11, 1'b1, "mvn_b2b", 5, '{P_WAIT, P_DEC, P_LDB, P_EXA, P_WRR, P_NONE});
    run(3'b110, 2'b00, 1'b1, "movr_b2b", 5, '{P_WAIT, P_DEC, P_LDB, P_EXA, P_WRR, P_NONE});
    run(3'b110, 2'b10, 1'b1, "movi_b2b", 3, '{P_WAIT, P_DEC, P_WRI, P_NONE, P_NONE, P_NONE});
    run(3'b101, 2'b01, 1'b1, "cmp_b2b", 5, '{P_WAIT, P_DEC, P_LDA, P_LDB, P_CMP, P_NONE});
    idle(2, "gap2");

    // Reset in S_EXEC of ADD aborts the write.
    run(3'b101, 2'b00, 1'b0, "add_rst", 4, '{P_WAIT, P_DEC, P_LDA, P_LDB, P_NONE, P_NONE});
    push(P_EXC, "add_rst[exec]");
    @(negedge clk);
    #1;
    rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) push(P_WAIT, $sformatf("in_rst[%0d]", i));
    step();
    step();
    rst = 1'b0;
    step();
    idle(4, "after_abort");

`ifndef SEQ_CTRL_ILLEGAL_TRAP_EN
    run(3'b000, 2'b00, 1'b0, "nop_000", 2, '{P_WAIT, P_DEC, P_NONE, P_NONE, P_NONE, P_NONE});
    run(3'b110, 2'b01, 1'b1, "nop_110_01", 2, '{P_WAIT, P_DEC, P_NONE, P_NONE, P_NONE, P_NONE});
    run(3'b111, 2'b11, 1'b1, "nop_111_11", 2, '{P_WAIT, P_DEC, P_NONE, P_NONE, P_NONE, P_NONE});
    run(3'b110, 2'b10, 1'b0, "mov_after_nop", 3, '{P_WAIT, P_DEC, P_WRI, P_NONE, P_NONE, P_NONE});
    idle(2, "tail");
`else
    run(3'b000, 2'b00, 1'b0, "trap", 2, '{P_WAIT, P_DEC, P_NONE, P_NONE, P_NONE, P_NONE});
    for (int i = 0; i < 5; i++) push(P_HALT, $sformatf("halt[%0d]", i));
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      step();
    end
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) push(P_WAIT, $sformatf("halt_rst[%0d]", i));
    repeat (2) step();
    rst = 1'b0;
    run(3'b110, 2'b10, 1'b0, "mov_after_trap", 3, '{P_WAIT, P_DEC, P_WRI, P_NONE, P_NONE, P_NONE});
    idle(2, "tail");
`endif

    step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
